charge_trigger: RTL and testbench



---
 rtl/jk_tune_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/charge_trigger.sv | 95 +++++++++
 tb/tb_charge_trigger.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_tune_pkg.sv
// Shared constants and types for the charge-tune trigger and tune player.
package jk_tune_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    LOCK = 2'd2
  } trig_state_t;

  // Note durations in clk cycles, shared with the tune player's duration counter.
  localparam logic [31:0] DUR_SHORT  = 32'h0040_0000;
  localparam logic [31:0] DUR_LONG   = 32'h0080_0000;
  localparam logic [31:0] DUR_DOTTED = 32'h00C0_0000;

  // 3*long + 7*short plus an 8-cycle margin.
  localparam logic [31:0] TUNE_LEN = 32'd54525960;

  localparam logic [31:0] STEP_FAST = 32'd15;
  localparam logic [31:0] STEP_IMPL = 32'd1;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer, debouncer and press detector.
// Emits one press pulse per debounced falling edge of btn_n.
module btn_debounce #(
  parameter int unsigned FAST_SIM = 1,
  parameter int unsigned DB_BITS  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic o_press
);

  localparam int unsigned CW = (FAST_SIM != 0) ? 4 : DB_BITS;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_db_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Counter runs only while the synced level disagrees with the debounced one,
  // so any return to the old level restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_db    <= 1'b1;
      r_db_d  <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= btn_n;
      r_s2    <= r_s1;
      r_db_d  <= r_db;
      r_press <= r_db_d & ~r_db;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == {CW{1'b1}}) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/charge_trigger.sv
// Merges tune requests, issues one go per tune and queues up to three
// requests that arrive while the player is locked out.
module charge_trigger
  import jk_tune_pkg::*;
#(
  parameter int unsigned FAST_SIM = 1,
  parameter int unsigned DB_BITS  = 20,
  parameter logic [31:0] LOCK_LEN = TUNE_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       cmd_req,
  input  logic       tour_done,
  output logic       go,
  output logic       busy,
  output logic [1:0] pending,
  output logic       overflow
);

  localparam logic [31:0] STEP = (FAST_SIM != 0) ? STEP_FAST : STEP_IMPL;

  trig_state_t r_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_pend;
  logic        r_go;
  logic        r_busy;
  logic        r_ovf;
  logic        w_btn_req;
  logic        w_req;

  btn_debounce #(
    .FAST_SIM (FAST_SIM),
    .DB_BITS  (DB_BITS)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .o_press (w_btn_req)
  );

  assign w_req = cmd_req | tour_done | w_btn_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 2'd0;
      r_go    <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_go  <= 1'b0;
      r_ovf <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req || (r_pend != 2'd0)) begin
            r_state <= FIRE;
            r_go    <= 1'b1;
            r_busy  <= 1'b1;
            // A fresh req replaces the consumed queue entry, so only dequeue without one.
            if (!w_req) r_pend <= r_pend - 2'd1;
          end
        end
        FIRE: begin
          r_cnt   <= '0;
          r_state <= LOCK;
        end
        LOCK: begin
          if (r_cnt >= LOCK_LEN) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + STEP;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if ((r_state != IDLE) && w_req) begin
        if (r_pend == 2'd3) r_ovf  <= 1'b1;
        else                r_pend <= r_pend + 2'd1;
      end
    end
  end

  assign go       = r_go;
  assign busy     = r_busy;
  assign pending  = r_pend;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_charge_trigger.sv
// Directed bench for charge_trigger with a shortened lockout (600 / step 15).
module tb_charge_trigger;

  // FIRE + 41 LOCK cycles busy; tune-to-tune spacing 600/15 + 3.
  localparam int BUSY_LEN = 42;
  localparam int SPACING  = 43;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       cmd_req;
  logic       tour_done;
  logic       go;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int go_cnt   = 0;
  int ovf_cnt  = 0;
  int cyc      = 0;

  charge_trigger #(
    .FAST_SIM (1),
    .DB_BITS  (20),
    .LOCK_LEN (32'd600)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_n),
    .cmd_req   (cmd_req),
    .tour_done (tour_done),
    .go        (go),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (go === 1'b1) go_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd();
    cmd_req = 1'b1;
    tick(1);
    cmd_req = 1'b0;
  endtask

  task automatic wait_go(input string tag, input int limit);
    int n;
    n = 0;
    while (go !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(go), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;

    rst_n = 1'b0; btn_n = 1'b1; cmd_req = 1'b0; tour_done = 1'b0;
    tick(3);
    chk("rst_go",       32'(go),       32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_pending",  32'(pending),  32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(6);
    chk("idle_no_go", 32'(go), 32'd0);

    // Single cmd_req: go next cycle, busy for the whole lockout.
    pulse_cmd();
    chk("t1_go",      32'(go),      32'd1);
    chk("t1_busy",    32'(busy),    32'd1);
    chk("t1_pending", 32'(pending), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick(1);
    end
    chk("t1_busy_len", 32'(n),       32'(BUSY_LEN));
    chk("t1_go_cnt",   32'(go_cnt),  32'd1);
    chk("t1_pend_end", 32'(pending), 32'd0);

    // Simultaneous cmd_req and tour_done merge into one request.
    cmd_req = 1'b1; tour_done = 1'b1;
    tick(1);
    cmd_req = 1'b0; tour_done = 1'b0;
    chk("t2_go",      32'(go),      32'd1);
    chk("t2_pending", 32'(pending), 32'd0);
    wait_idle("t2_idle", 100);
    chk("t2_go_cnt", 32'(go_cnt), 32'd2);

    // Four requests during LOCK: queue saturates at 3, fourth overflows.
    pulse_cmd();
    chk("t3_go", 32'(go), 32'd1);
    t0 = cyc;
    tick(2);
    for (int i = 1; i <= 4; i++) begin
      pulse_cmd();
      chk($sformatf("t3_pend_%0d", i), 32'(pending), (i >= 3) ? 32'd3 : 32'(i));
      chk($sformatf("t3_ovf_%0d", i), 32'(overflow), (i == 4) ? 32'd1 : 32'd0);
      tick(1);
    end
    chk("t3_ovf_clear", 32'(overflow), 32'd0);
    chk("t3_ovf_cnt",   32'(ovf_cnt),  32'd1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      wait_go($sformatf("t3_qgo_%0d", k), 100);
      chk($sformatf("t3_space_%0d", k), 32'(cyc - t0), 32'(SPACING));
      chk($sformatf("t3_qpend_%0d", k), 32'(pending), 32'(2 - k));
      t0 = cyc;
    end
    wait_idle("t3_idle", 100);
    tick(30);
    chk("t3_go_cnt",  32'(go_cnt),  32'd6);
    chk("t3_pend_end", 32'(pending), 32'd0);

    // Button: short glitches are ignored, a stable press fires once.
    for (int i = 0; i < 3; i++) begin
      btn_n = 1'b0; tick(5);
      btn_n = 1'b1; tick(5);
    end
    tick(30);
    chk("t4_bounce_no_go", 32'(go_cnt), 32'd6);
    btn_n = 1'b0;
    n = 0;
    while (go !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk("t4_btn_go",      32'(go), 32'd1);
    chk("t4_btn_latency", 32'((n >= 19) && (n <= 21)), 32'd1);
    if (n < 40) tick(40 - n);
    chk("t4_held_once", 32'(go_cnt), 32'd7);
    btn_n = 1'b1;
    tick(80);
    chk("t4_release_no_go", 32'(go_cnt), 32'd7);
    chk("t4_busy_end",      32'(busy),   32'd0);

    // Reset mid-LOCK discards the queue without issuing go.
    pulse_cmd();
    chk("t5_go", 32'(go), 32'd1);
    tick(2);
    pulse_cmd(); tick(1);
    pulse_cmd(); tick(1);
    chk("t5_pend2", 32'(pending), 32'd2);
    tick(14);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pending", 32'(pending), 32'd0);
    chk("t5_rst_busy",    32'(busy),    32'd0);
    chk("t5_rst_go",      32'(go),      32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("t5_no_go_after", 32'(go_cnt), 32'd8);
    pulse_cmd();
    chk("t5_post_go", 32'(go), 32'd1);

    // Request on the first IDLE cycle with one queued entry.
    tick(2);
    pulse_cmd();
    chk("t6_pend1", 32'(pending), 32'd1);
    wait_idle("t6_idle", 100);
    chk("t6_pend_idle", 32'(pending), 32'd1);
    pulse_cmd();
    chk("t6_go",      32'(go),      32'd1);
    chk("t6_pending", 32'(pending), 32'd1);
    t0 = cyc;
    tick(1);
    wait_go("t6_go2", 100);
    chk("t6_space",    32'(cyc - t0), 32'(SPACING));
    chk("t6_pend_go2", 32'(pending),  32'd0);
    wait_idle("t6_idle2", 100);
    tick(20);
    chk("t6_go_cnt",  32'(go_cnt),  32'd11);
    chk("t6_pend_end", 32'(pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
